nand3_cell_exerciser: RTL and testbench

A self-timed exerciser for an array of NAND3 standard cells. It drives every 3-input combination onto N_CELLS parallel cell instances and samples each ZN after a programmable settle time. It compares each sample against the ideal NAND3 function, then reports a per-cell fail map and a saturating error count. It sits beside the cell array on silicon test structures and in gate-level library regression benches, acting as the stimulus and response end of the cells' A1/A2/A3 → ZN interface.

---
 rtl/nand3_cell_exerciser_pkg.sv | 32 +++
 rtl/nand3_cell_exerciser_vecgen.sv | 64 ++++++
 rtl/nand3_cell_exerciser.sv | 137 +++++++++++++
 tb/tb_nand3_cell_exerciser.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/nand3_cell_exerciser_pkg.sv
// Shared types and helpers for the NAND3 cell exerciser.
// Gray sequencing is selected by NAND3_CELL_EXERCISER_GRAY_EN (see vecgen).
package nand3_cell_exerciser_pkg;

  localparam int unsigned NUM_VEC = 8;
  localparam int unsigned VEC_W   = 3;
  localparam int unsigned ERR_W   = 8;
  localparam int unsigned SCNT_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_FINISH = 2'd3
  } state_e;

  // One 3-input pattern as seen by a cell: bit 0 is A1.
  typedef struct packed {
    logic a3;
    logic a2;
    logic a1;
  } pat_t;

  function automatic logic [VEC_W-1:0] gray_of(input logic [VEC_W-1:0] v);
    return v ^ (v >> 1);
  endfunction

  function automatic logic zn_exp(input logic [VEC_W-1:0] p);
    return ~&p;
  endfunction

endpackage

// File: rtl/nand3_cell_exerciser_vecgen.sv
// Vector index, settle timer and registered pattern for the exerciser.
// NAND3_CELL_EXERCISER_GRAY_EN selects Gray-ordered patterns instead of binary.
module nand3_cell_exerciser_vecgen
  import nand3_cell_exerciser_pkg::*;
#(
  parameter int unsigned SETTLE_CYC = 2
) (
  input  logic CLK,
  input  logic RN,
  input  logic load,
  input  logic in_settle,
  input  logic advance,
  input  logic clear,
  output pat_t pat,
  output logic settle_done_c,
  output logic last_c
);

  localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(SETTLE_CYC - 1);
  localparam logic [VEC_W-1:0]  V_LAST    = VEC_W'(NUM_VEC - 1);

  logic [VEC_W-1:0]  v_q;
  logic [SCNT_W-1:0] scnt_q;

  function automatic pat_t pat_of(input logic [VEC_W-1:0] v);
`ifdef NAND3_CELL_EXERCISER_GRAY_EN
    return pat_t'(gray_of(v));
`else
    return pat_t'(v);
`endif
  endfunction

  // Vector index and the pattern driven onto the cells.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      v_q <= '0;
      pat <= '0;
    end else if (load) begin
      v_q <= '0;
      pat <= pat_of(VEC_W'(0));
    end else if (advance) begin
      v_q <= VEC_W'(v_q + 1'b1);
      pat <= pat_of(VEC_W'(v_q + 1'b1));
    end else if (clear) begin
      v_q <= '0;
      pat <= '0;
    end
  end

  // Counts cycles spent in SETTLE; idles at zero otherwise.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      scnt_q <= '0;
    end else if (load || !in_settle || (scnt_q == SCNT_LAST)) begin
      scnt_q <= '0;
    end else begin
      scnt_q <= SCNT_W'(scnt_q + 1'b1);
    end
  end

  assign settle_done_c = in_settle && (scnt_q == SCNT_LAST);
  assign last_c        = (v_q == V_LAST);

endmodule

// File: rtl/nand3_cell_exerciser.sv
// Drives all 3-input patterns onto N_CELLS NAND3 cells and scores ZN.
// Optional Gray ordering via NAND3_CELL_EXERCISER_GRAY_EN.
module nand3_cell_exerciser
  import nand3_cell_exerciser_pkg::*;
#(
  parameter int unsigned N_CELLS    = 4,
  parameter int unsigned SETTLE_CYC = 2
) (
  input  logic               CLK,
  input  logic               RN,
  input  logic               START,
  output logic [N_CELLS-1:0] A1,
  output logic [N_CELLS-1:0] A2,
  output logic [N_CELLS-1:0] A3,
  input  logic [N_CELLS-1:0] ZN,
  output logic               BUSY,
  output logic               DONE,
  output logic               PASS,
  output logic [ERR_W-1:0]   ERR_CNT,
  output logic [N_CELLS-1:0] FAIL_MAP
);

  localparam int unsigned POP_W   = $clog2(N_CELLS + 1);
  localparam int unsigned SUM_W   = ERR_W + 1;
  localparam int unsigned ERR_MAX = (1 << ERR_W) - 1;

  state_e             state_q, state_d;
  logic               busy_d, done_d, pass_d;
  logic [ERR_W-1:0]   err_d;
  logic [N_CELLS-1:0] fmap_d;
  logic               load_c, advance_c, clear_c;
  logic               settle_done_c, last_c;
  pat_t               pat;
  logic [N_CELLS-1:0] mism_c;
  logic [POP_W-1:0]   pop_c;
  logic [SUM_W-1:0]   sum_c;
  logic [ERR_W-1:0]   err_sat_c;

  nand3_cell_exerciser_vecgen #(
    .SETTLE_CYC (SETTLE_CYC)
  ) u_vecgen (
    .CLK           (CLK),
    .RN            (RN),
    .load          (load_c),
    .in_settle     (state_q == ST_SETTLE),
    .advance       (advance_c),
    .clear         (clear_c),
    .pat           (pat),
    .settle_done_c (settle_done_c),
    .last_c        (last_c)
  );

  assign A1 = {N_CELLS{pat.a1}};
  assign A2 = {N_CELLS{pat.a2}};
  assign A3 = {N_CELLS{pat.a3}};

  // Per-cell mismatch against ideal NAND3 and saturating accumulation.
  assign mism_c = ZN ^ {N_CELLS{zn_exp(pat)}};

  always_comb begin
    pop_c = '0;
    for (int unsigned i = 0; i < N_CELLS; i++) begin
      pop_c = POP_W'(pop_c + POP_W'(mism_c[i]));
    end
  end

  assign sum_c     = SUM_W'(ERR_CNT) + SUM_W'(pop_c);
  assign err_sat_c = (sum_c > SUM_W'(ERR_MAX)) ? ERR_W'(ERR_MAX) : sum_c[ERR_W-1:0];

  always_comb begin
    state_d   = state_q;
    busy_d    = BUSY;
    done_d    = 1'b0;
    pass_d    = PASS;
    err_d     = ERR_CNT;
    fmap_d    = FAIL_MAP;
    load_c    = 1'b0;
    advance_c = 1'b0;
    clear_c   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          state_d = ST_SETTLE;
          busy_d  = 1'b1;
          pass_d  = 1'b0;
          err_d   = '0;
          fmap_d  = '0;
          load_c  = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (settle_done_c) begin
          state_d = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        fmap_d = FAIL_MAP | mism_c;
        err_d  = err_sat_c;
        if (last_c) begin
          state_d = ST_FINISH;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_sat_c == '0);
          clear_c = 1'b1;
        end else begin
          state_d   = ST_SETTLE;
          advance_c = 1'b1;
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_q  <= ST_IDLE;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      PASS     <= 1'b0;
      ERR_CNT  <= '0;
      FAIL_MAP <= '0;
    end else begin
      state_q  <= state_d;
      BUSY     <= busy_d;
      DONE     <= done_d;
      PASS     <= pass_d;
      ERR_CNT  <= err_d;
      FAIL_MAP <= fmap_d;
    end
  end

endmodule

// File: tb/tb_nand3_cell_exerciser.sv
// Self-checking bench for nand3_cell_exerciser: fault-injecting cell model,
// table-driven runs, random faults against a count-based reference, corner sequences.
`timescale 1ns/1ps
module tb_nand3_cell_exerciser;

  localparam int unsigned N   = 4;
  localparam int unsigned NB  = 32;
  localparam int unsigned S   = 2;
  localparam int          LAT = 8 * (S + 1);

  // Fault codes per cell: 0 ideal, 1 stuck-at-0, 2 stuck-at-1, 3 behaves as AND3.
  typedef struct {
    string              name;
    logic [N-1:0][1:0]  fault;
    int                 exp_err;
    logic [N-1:0]       exp_fmap;
    logic               exp_pass;
  } vec_t;

  logic clk = 1'b0;
  logic rn = 1'b0;
  logic start = 1'b0;
  logic [N-1:0] a1, a2, a3, zn, fmap;
  logic busy, done, pass;
  logic [7:0] err;
  logic [NB-1:0] a1_32, a2_32, a3_32, zn32, fmap32;
  logic busy32, done32, pass32;
  logic [7:0] err32;

  logic [N-1:0][1:0] fault = '0;
  logic [7:0][N-1:0] flip = '0;

  int n_pass = 0;
  int n_chk = 0;
  int exp_order[8];
  int lat, busy_n, rep_bad;
  int seq[$];
  int cap_err32;
  logic [NB-1:0] cap_fmap32;
  logic cap_pass32;

  always #5 clk = ~clk;

  function automatic logic cell_zn(input logic [1:0] f, input logic [2:0] p, input logic fl);
    logic r;
    case (f)
      2'd0: r = ~&p;
      2'd1: r = 1'b0;
      2'd2: r = 1'b1;
      default: r = &p;
    endcase
    return r ^ fl;
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_cell
    assign zn[g] = cell_zn(fault[g], {a3[g], a2[g], a1[g]}, flip[{a3[g], a2[g], a1[g]}][g]);
  end
  assign zn32 = a1_32 & a2_32 & a3_32;

  nand3_cell_exerciser #(.N_CELLS(N), .SETTLE_CYC(S)) dut (
    .CLK(clk), .RN(rn), .START(start), .A1(a1), .A2(a2), .A3(a3), .ZN(zn),
    .BUSY(busy), .DONE(done), .PASS(pass), .ERR_CNT(err), .FAIL_MAP(fmap)
  );

  nand3_cell_exerciser #(.N_CELLS(NB), .SETTLE_CYC(S)) dut32 (
    .CLK(clk), .RN(rn), .START(start), .A1(a1_32), .A2(a2_32), .A3(a3_32), .ZN(zn32),
    .BUSY(busy32), .DONE(done32), .PASS(pass32), .ERR_CNT(err32), .FAIL_MAP(fmap32)
  );

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Reference: score every pattern 0..7 against ideal NAND3, regardless of order.
  task automatic model(output int e, output logic [N-1:0] fm);
    e = 0;
    fm = '0;
    for (int p = 0; p < 8; p++) begin
      for (int i = 0; i < N; i++) begin
        if (cell_zn(fault[i], 3'(p), flip[p][i]) != (p != 7)) begin
          e++;
          fm[i] = 1'b1;
        end
      end
    end
    if (e > 255) e = 255;
  endtask

  // Request a run at a negedge and observe it until DONE (bounded).
  task automatic do_run();
    int cyc;
    bit got;
    logic [2:0] p;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    cyc = 0; got = 0; busy_n = 0; rep_bad = 0; lat = -1;
    seq.delete();
    while (!got && cyc < 200) begin
      if (busy) begin
        busy_n++;
        p = {a3[0], a2[0], a1[0]};
        if (seq.size() == 0 || seq[$] != int'(p)) seq.push_back(int'(p));
      end
      if (a1 != {N{a1[0]}} || a2 != {N{a2[0]}} || a3 != {N{a3[0]}}) rep_bad++;
      if (done) begin
        got = 1;
        lat = cyc;
        cap_err32 = int'(err32);
        cap_fmap32 = fmap32;
        cap_pass32 = pass32;
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
  endtask

  task automatic run_and_check(input string nm, input int e_err, input logic [N-1:0] e_fm,
                               input logic e_pass);
    do_run();
    chk({nm, " done_latency"}, lat, LAT);
    chk({nm, " busy_cycles"}, busy_n, LAT);
    chk({nm, " replication"}, rep_bad, 0);
    chk({nm, " err_cnt"}, err, e_err);
    chk({nm, " fail_map"}, fmap, e_fm);
    chk({nm, " pass"}, pass, e_pass);
    chk({nm, " a_idle_at_done"}, {a1, a2, a3}, 0);
    chk({nm, " pattern_count"}, seq.size(), 8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("%s pattern[%0d]", nm, i), (i < seq.size()) ? seq[i] : -1, exp_order[i]);
`ifdef NAND3_CELL_EXERCISER_GRAY_EN
      if (i > 0 && i < seq.size())
        chk($sformatf("%s hamming[%0d]", nm, i), $countones(seq[i] ^ seq[i-1]), 1);
`endif
    end
    @(negedge clk);
    chk({nm, " done_pulse_width"}, done, 0);
    chk({nm, " busy_after"}, busy, 0);
    chk({nm, " err_hold"}, err, e_err);
  endtask

  vec_t tbl[4];

  initial begin
    int e;
    logic [N-1:0] fm;
    int dn, first_done, rise, err_rise, err_first;
    logic prev_busy;
    bit found;

`ifdef NAND3_CELL_EXERCISER_GRAY_EN
    exp_order = '{0, 1, 3, 2, 6, 7, 5, 4};
`else
    exp_order = '{0, 1, 2, 3, 4, 5, 6, 7};
`endif
    tbl[0] = '{name: "ideal",        fault: 8'h00, exp_err: 0,  exp_fmap: 4'b0000, exp_pass: 1'b1};
    tbl[1] = '{name: "cell2_stuck1", fault: 8'h20, exp_err: 1,  exp_fmap: 4'b0100, exp_pass: 1'b0};
    tbl[2] = '{name: "all_and3",     fault: 8'hFF, exp_err: 32, exp_fmap: 4'b1111, exp_pass: 1'b0};
    tbl[3] = '{name: "cell0_stuck0", fault: 8'h01, exp_err: 7,  exp_fmap: 4'b0001, exp_pass: 1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset outputs", {a1, a2, a3, busy, done, pass, err, fmap}, 0);
    rn = 1'b1;
    @(negedge clk);
    chk("idle after reset", {a1, a2, a3, busy, done, pass, err, fmap}, 0);

    // Table-driven runs
    for (int t = 0; t < 4; t++) begin
      fault = tbl[t].fault;
      flip = '0;
      run_and_check(tbl[t].name, tbl[t].exp_err, tbl[t].exp_fmap, tbl[t].exp_pass);
      if (t == 0) begin
        chk("n32 and3 err saturates", cap_err32, 255);
        chk("n32 and3 fail_map", cap_fmap32, {NB{1'b1}});
        chk("n32 and3 pass", cap_pass32, 0);
      end
    end

    // START held high: two back-to-back runs, results cleared by the second START
    fault = {N{2'd3}};
    flip = '0;
    start = 1'b1;
    dn = 0; first_done = -1; rise = -1; err_rise = -1; err_first = -1;
    prev_busy = busy;
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      if (c == 40) start = 1'b0;
      if (done) begin
        dn++;
        if (first_done < 0) begin first_done = c; err_first = int'(err); end
      end
      if (busy && !prev_busy && first_done >= 0 && rise < 0) begin
        rise = c;
        err_rise = int'(err);
      end
      prev_busy = busy;
    end
    start = 1'b0;
    chk("held_start done_count", dn, 2);
    chk("held_start first_done", first_done, LAT);
    chk("held_start restart_gap", rise - first_done, 2);
    chk("held_start err_before", err_first, 32);
    chk("held_start err_cleared", err_rise, 0);

    // Reset during vector 3 aborts the run
    fault = 8'h01;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    found = 0;
    for (int c = 0; c < 100 && !found; c++) begin
      @(negedge clk);
      if (int'({a3[0], a2[0], a1[0]}) == exp_order[3]) found = 1;
    end
    chk("abort reached vector3", found, 1);
    chk("abort err nonzero before reset", (err != 0), 1);
    #2 rn = 1'b0;
    #1;
    chk("abort outputs zero", {a1, a2, a3, busy, done, pass, err, fmap}, 0);
    @(negedge clk);
    rn = 1'b1;
    dn = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done || busy) dn++;
    end
    chk("abort no done", dn, 0);
    fault = '0;
    run_and_check("after_abort", 0, 4'b0000, 1'b1);

    // Random faults against the reference
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < N; i++) fault[i] = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      for (int p = 0; p < 8; p++)
        for (int i = 0; i < N; i++) flip[p][i] = ($urandom_range(0, 7) == 0);
      model(e, fm);
      run_and_check($sformatf("rand%0d", r), e, fm, (e == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
